// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser: splits a change amount into 20c/10c/5c coins (largest
// first) and drives one timed eject pulse per coin, with a fixed low gap after
// every pulse. Reports busy/done and flags amounts that are not multiples of 5.
// Optional build macro COIN_TALLY_EN adds saturating per-coin-type counters
// (tally20/tally10/tally5); without it those ports and their logic are absent.
module coin_change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES   = 5_000_000,
  parameter int unsigned CNT_W        = 23
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] amount,
  output logic       eject20,
  output logic       eject10,
  output logic       eject5,
  output logic       busy,
  output logic       done,
  output logic       remainder_err,
  output logic [5:0] remaining
`ifdef COIN_TALLY_EN
  ,
  output logic [7:0] tally20,
  output logic [7:0] tally10,
  output logic [7:0] tally5
`endif
);

  localparam int unsigned AMT_W   = 6;
  localparam int unsigned COIN_W  = 3;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    timer_q;
  logic [COIN_W-1:0]   eject_q;      // {20c, 10c, 5c}, at most one bit set
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [AMT_W-1:0]    remaining_q;

  logic [AMT_W-1:0]    residue_c;
  logic [AMT_W-1:0]    coin_val_c;
  logic [COIN_W-1:0]   coin_oh_c;
  logic                advance_c;
  logic                launch_c;

  // Residue that is discarded when the amount is captured.
  always_comb begin
    residue_c = amount % AMT_W'(5);
  end

  // Largest coin that still fits, and whether a new coin may start this cycle.
  always_comb begin
    coin_val_c = '0;
    coin_oh_c  = '0;
    if (remaining_q >= AMT_W'(20)) begin
      coin_val_c = AMT_W'(20);
      coin_oh_c  = 3'b100;
    end else if (remaining_q >= AMT_W'(10)) begin
      coin_val_c = AMT_W'(10);
      coin_oh_c  = 3'b010;
    end else if (remaining_q >= AMT_W'(5)) begin
      coin_val_c = AMT_W'(5);
      coin_oh_c  = 3'b001;
    end
    advance_c = (state_q == S_SELECT) || ((state_q == S_GAP) && (timer_q == '0));
    launch_c  = advance_c && (coin_oh_c != '0);
  end

  // Sequencer: state, shared pulse/gap timer and all status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      eject_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q <= amount - residue_c;
            err_q       <= (residue_c != '0);
            timer_q     <= '0;
            state_q     <= S_SELECT;
          end
        end
        S_SELECT, S_GAP: begin
          if (launch_c) begin
            eject_q     <= coin_oh_c;
            remaining_q <= remaining_q - coin_val_c;
            timer_q     <= PULSE_LOAD;
            busy_q      <= 1'b1;
            state_q     <= S_PULSE;
          end else if (advance_c) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b1;
            timer_q <= '0;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (timer_q == '0) begin
            eject_q <= '0;
            timer_q <= GAP_LOAD;
            state_q <= S_GAP;
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          timer_q <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign eject20       = eject_q[2];
  assign eject10       = eject_q[1];
  assign eject5        = eject_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign remainder_err = err_q;
  assign remaining     = remaining_q;

`ifdef COIN_TALLY_EN
  localparam int unsigned TALLY_W = 8;

  logic [TALLY_W-1:0] tally20_q, tally10_q, tally5_q;
  logic [TALLY_W-1:0] tally20_d, tally10_d, tally5_d;

  // Saturating coin counters, bumped on the edge a pulse starts.
  always_comb begin
    tally20_d = tally20_q;
    tally10_d = tally10_q;
    tally5_d  = tally5_q;
    if (launch_c) begin
      if (coin_oh_c[2] && (tally20_q != '1)) tally20_d = tally20_q + TALLY_W'(1);
      if (coin_oh_c[1] && (tally10_q != '1)) tally10_d = tally10_q + TALLY_W'(1);
      if (coin_oh_c[0] && (tally5_q  != '1)) tally5_d  = tally5_q  + TALLY_W'(1);
    end
  end

  // Tally registers; cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tally20_q <= '0;
      tally10_q <= '0;
      tally5_q  <= '0;
    end else begin
      tally20_q <= tally20_d;
      tally10_q <= tally10_d;
      tally5_q  <= tally5_d;
    end
  end

  assign tally20 = tally20_q;
  assign tally10 = tally10_q;
  assign tally5  = tally5_q;
`endif

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Randomized bench for coin_change_dispenser, checked cycle by cycle against an
// arithmetic model of the coin schedule (greedy coin counts, fixed slot length).
module tb_coin_change_dispenser;

  localparam int unsigned P = 3;
  localparam int unsigned G = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [5:0] amount;
  logic       eject20, eject10, eject5, busy, done, remainder_err;
  logic [5:0] remaining;
`ifdef COIN_TALLY_EN
  logic [7:0] tally20, tally10, tally5;
  int m20, m10, m5;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  coin_change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(23)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .amount(amount),
    .eject20(eject20), .eject10(eject10), .eject5(eject5),
    .busy(busy), .done(done), .remainder_err(remainder_err), .remaining(remaining)
`ifdef COIN_TALLY_EN
    , .tally20(tally20), .tally10(tally10), .tally5(tally5)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] observed();
    return {eject20, eject10, eject5, busy, done, remainder_err, remaining};
  endfunction

  // Coin value of the idx-th coin in the greedy plan for rounded amount r0.
  function automatic int coin_at(int r0, int idx);
    int n20 = r0 / 20;
    int n10 = (r0 % 20) / 10;
    if (idx < n20) return 20;
    if (idx < n20 + n10) return 10;
    return 5;
  endfunction

  function automatic int n_coins(int a);
    int r0 = a - (a % 5);
    return r0 / 20 + (r0 % 20) / 10 + (r0 % 10) / 5;
  endfunction

  function automatic int done_k(int a);
    return 1 + n_coins(a) * int'(P + G);
  endfunction

  // Expected {ej20,ej10,ej5,busy,done,err,remaining} k cycles after the start edge.
  function automatic logic [11:0] model(int a, int k);
    int   r0  = a - (a % 5);
    logic err = (a % 5) != 0;
    int   dk  = done_k(a);
    int   per = int'(P + G);
    int   idx, ph, val, rem;
    logic [2:0] ej;
    if (k == 0) return {3'b000, 1'b0, 1'b0, err, 6'(r0)};
    if (k < dk) begin
      idx = (k - 1) / per;
      ph  = (k - 1) % per;
      val = coin_at(r0, idx);
      rem = r0;
      for (int i = 0; i <= idx; i++) rem -= coin_at(r0, i);
      ej = 3'b000;
      if (ph < int'(P)) ej = (val == 20) ? 3'b100 : (val == 10) ? 3'b010 : 3'b001;
      return {ej, 1'b1, 1'b0, err, 6'(rem)};
    end
    if (k == dk) return {3'b000, 1'b1, 1'b1, err, 6'd0};
    return {3'b000, 1'b0, 1'b0, err, 6'd0};
  endfunction

  // One sale; optional spurious start sampled at edge N+mid_k and at DONE->IDLE.
  task automatic run_seq(input int a, input int mid_k, input bit start_at_done, input string tag);
    int dk = done_k(a);
    @(negedge clk);
    start  = 1'b1;
    amount = 6'(a);
    @(posedge clk);
    #1;
    start  = 1'b0;
    amount = 6'($urandom);
    check($sformatf("%s a=%0d k=0", tag, a), 32'(observed()), 32'(model(a, 0)));
    for (int k = 1; k <= dk + 2; k++) begin
      start  = (k == mid_k) || (start_at_done && (k == dk + 1));
      amount = 6'($urandom);
      @(posedge clk);
      #1;
      start = 1'b0;
      check($sformatf("%s a=%0d k=%0d", tag, a, k), 32'(observed()), 32'(model(a, k)));
    end
`ifdef COIN_TALLY_EN
    begin
      int r0 = a - (a % 5);
      m20 = (m20 + r0 / 20 > 255) ? 255 : m20 + r0 / 20;
      m10 = (m10 + (r0 % 20) / 10 > 255) ? 255 : m10 + (r0 % 20) / 10;
      m5  = (m5 + (r0 % 10) / 5 > 255) ? 255 : m5 + (r0 % 10) / 5;
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    amount  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(observed()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`ifdef COIN_TALLY_EN
    m20 = 0; m10 = 0; m5 = 0;
`endif
    @(posedge clk);
    #1;
    check("idle_after_reset", 32'(observed()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    amount  = '0;
`ifdef COIN_TALLY_EN
    m20 = 0; m10 = 0; m5 = 0;
`endif
    do_reset();

    // Directed cases from the plan.
    run_seq(35, 0, 1'b0, "amt35");
    run_seq(0, 0, 1'b1, "amt0");
    run_seq(4, 0, 1'b0, "amt4");
    run_seq(63, 0, 1'b1, "amt63");
    run_seq(25, 4, 1'b0, "amt25_midstart");
    run_seq(5, 1, 1'b1, "amt5");
    run_seq(60, 0, 1'b0, "amt60");

    // Asynchronous reset in the middle of a 45c sequence.
    @(negedge clk);
    start  = 1'b1;
    amount = 6'd45;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("amt45_pre_rst k=%0d", k), 32'(observed()), 32'(model(45, k)));
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    check("held_reset_outputs", 32'(observed()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`ifdef COIN_TALLY_EN
    m20 = 0; m10 = 0; m5 = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_idle c=%0d", k), 32'(observed()), 32'd0);
    end
    run_seq(10, 0, 1'b0, "amt10_after_rst");

    // Random sales with random spurious starts.
    for (int i = 0; i < 30; i++) begin
      int a   = int'($urandom_range(0, 63));
      int mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, done_k(a))) : 0;
      run_seq(a, mid, 1'($urandom_range(0, 1)), "rand");
    end

`ifdef COIN_TALLY_EN
    do_reset();
    for (int i = 0; i < 13; i++) run_seq(35, 0, 1'b0, "tally35");
    check("tally20_13", 32'(tally20), 32'(m20));
    check("tally10_13", 32'(tally10), 32'(m10));
    check("tally5_13", 32'(tally5), 32'(m5));
    check("tally20_is13", 32'(tally20), 32'd13);
    for (int i = 0; i < 81; i++) run_seq(60, 0, 1'b0, "tally60");
    check("tally20_sat", 32'(tally20), 32'd255);
    check("tally10_hold", 32'(tally10), 32'd13);
    check("tally5_hold", 32'(tally5), 32'd13);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
